// File: rtl/rf_pkg.sv
// Shared definitions for the parameterised register file.
//   clr_state_t : encoding of the clear-sweep FSM (IDLE=0, SWEEP=1)
//   clog2       : address width helper; returns at least 1 so a
//                 DEPTH of 1 or 2 still yields a usable address bus.
package rf_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } clr_state_t;

    function automatic int clog2(input int n);
        int w;
        int v;
        w = 0;
        v = n - 1;
        while (v > 0) begin
            w = w + 1;
            v = v >> 1;
        end
        if (w == 0) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// Clear-sweep sequencer for the register file.
// Ports:
//   clock, reset  : rising-edge clock, asynchronous active-high reset
//   clr_req       : start a sweep (sampled only while IDLE)
//   clr_busy      : registered, high exactly while the FSM is in SWEEP
//   clr_idx       : index of the register being cleared this cycle
//   clr_strobe    : high in every sweep cycle; clear clr_idx at this edge
//   state         : current FSM state, exposed for observation
// A sweep visits indices 0..DEPTH-1, one per edge, so it takes exactly
// DEPTH cycles from the first SWEEP edge back to IDLE.
module rf_clear_seq
    import rf_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clr_req,
    output logic          clr_busy,
    output logic [AW-1:0] clr_idx,
    output logic          clr_strobe,
    output clr_state_t    state
);

    localparam int            DEPTH_M1 = DEPTH - 1;
    localparam logic [AW-1:0] LAST_IDX = DEPTH_M1[AW-1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            clr_idx  <= '0;
            clr_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state    <= SWEEP;
                        clr_idx  <= '0;
                        clr_busy <= 1'b1;
                    end
                end
                SWEEP: begin
                    // clr_req is ignored here; a request still high when
                    // the sweep finishes is picked up on the next IDLE edge.
                    if (clr_idx == LAST_IDX) begin
                        state    <= IDLE;
                        clr_idx  <= '0;
                        clr_busy <= 1'b0;
                    end else begin
                        clr_idx <= clr_idx + AW'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    clr_idx  <= '0;
                    clr_busy <= 1'b0;
                end
            endcase
        end
    end

    assign clr_strobe = (state == SWEEP);

endmodule

// File: rtl/param_register_file.sv
// Two-read / one-write register file with a busy scoreboard and a
// full-clear sweep.
// Ports:
//   clock, reset      : rising-edge clock, asynchronous active-high reset
//   ra0, ra1          : combinational read addresses
//   out0, out1        : read data (write bypass when a permitted write hits)
//   we, wa, wd        : write enable / address / data
//   bs, bsa           : set the busy bit of bsa (pending write issued)
//   busy0, busy1      : stored busy bits of ra0 / ra1, no same-cycle bypass
//   clr_req           : request a sweep that zeroes every register
//   clr_busy          : sweep in progress; writes, sets and bypass blocked
// Addresses >= DEPTH read as zero with busy 0; writes and sets to them
// are dropped. With ZERO_REG=1 register 0 is never written and reads 0.
module param_register_file
    import rf_pkg::*;
#(
    parameter int   WIDTH    = 32,
    parameter int   DEPTH    = 32,
    parameter int   ZERO_REG = 1,
    localparam int  AW       = clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [AW-1:0]    ra0,
    input  logic [AW-1:0]    ra1,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic             bs,
    input  logic [AW-1:0]    bsa,
    output logic             busy0,
    output logic             busy1,
    input  logic             clr_req,
    output logic             clr_busy
);

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
    localparam bit          ZR      = (ZERO_REG != 0);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] busy;

    logic [AW-1:0] clr_idx;
    logic          clr_strobe;
    clr_state_t    clr_state;

    logic wr_ok;
    logic set_ok;

    // One extra bit so the compare stays meaningful when DEPTH == 2**AW.
    function automatic logic in_range(input logic [AW-1:0] a);
        return ({1'b0, a} < DEPTH_W);
    endfunction

    function automatic logic is_zero_reg(input logic [AW-1:0] a);
        return ZR && (a == '0);
    endfunction

    rf_clear_seq #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear_seq (
        .clock      (clock),
        .reset      (reset),
        .clr_req    (clr_req),
        .clr_busy   (clr_busy),
        .clr_idx    (clr_idx),
        .clr_strobe (clr_strobe),
        .state      (clr_state)
    );

    // A write or set only lands while idle, inside the array, and not on a
    // hardwired zero register. wr_ok also qualifies the read bypass.
    assign wr_ok  = we && (clr_state == IDLE) && in_range(wa)  && !is_zero_reg(wa);
    assign set_ok = bs && (clr_state == IDLE) && in_range(bsa) && !is_zero_reg(bsa);

    always_comb begin
        out0 = '0;
        if (wr_ok && (wa == ra0)) begin
            out0 = wd;
        end else if (in_range(ra0) && !is_zero_reg(ra0)) begin
            out0 = regs[ra0];
        end
    end

    always_comb begin
        out1 = '0;
        if (wr_ok && (wa == ra1)) begin
            out1 = wd;
        end else if (in_range(ra1) && !is_zero_reg(ra1)) begin
            out1 = regs[ra1];
        end
    end

    assign busy0 = in_range(ra0) && !is_zero_reg(ra0) && busy[ra0];
    assign busy1 = in_range(ra1) && !is_zero_reg(ra1) && busy[ra1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else if (clr_strobe) begin
            regs[clr_idx] <= '0;
            busy[clr_idx] <= 1'b0;
        end else begin
            if (wr_ok) begin
                regs[wa] <= wd;
                busy[wa] <= 1'b0;
            end
            // Placed after the write so a same-edge set to wa wins.
            if (set_ok) begin
                busy[bsa] <= 1'b1;
            end
        end
    end

endmodule

// File: doc/param_register_file.md
PARAM_REGISTER_FILE -- requirements
Module: param_register_file

Interface
REQ-001 SHALL expose parameter WIDTH, default 32, data bits per register.
REQ-002 SHALL expose parameter DEPTH, default 32, number of registers (>=2, need not be a power of two).
REQ-003 SHALL expose parameter ZERO_REG, default 1; 1 = register 0 hardwired to zero.
REQ-004 SHALL derive localparam AW = clog2(DEPTH), address width.
REQ-005 SHALL have ports:
clock  in  1  sole clock, rising edge.
reset  in  1  asynchronous, active-high.
ra0  in  AW  read address, port 0.
ra1  in  AW  read address, port 1.
out0  out  WIDTH  read data, port 0.
out1  out  WIDTH  read data, port 1.
we  in  1  write enable.
wa  in  AW  write address.
wd  in  WIDTH  write data.
bs  in  1  scoreboard set (pending write issued).
bsa  in  AW  scoreboard set address.
busy0  out  1  pending flag of ra0.
busy1  out  1  pending flag of ra1.
clr_req  in  1  request full clear sweep.
clr_busy  out  1  clear sweep in progress.

Function
REQ-006 Reads SHALL be combinational; out0/out1 = stored word at ra0/ra1.
REQ-007 Write SHALL occur at rising clock edge when we=1, clr_busy=0, wa<DEPTH, and not (ZERO_REG=1 and wa=0).
REQ-008 Bypass: when clr_busy=0, we=1 and wa equals a read address with a write permitted by REQ-007, that port SHALL output wd in the same cycle.
REQ-009 ZERO_REG=1: reads of address 0 SHALL return 0; busy flag of address 0 SHALL read 0.
REQ-010 Addresses >=DEPTH SHALL read 0 with busy 0, and writes/sets to them SHALL be ignored.
REQ-011 Scoreboard: one busy bit per register; bs=1 at edge SHALL set bit bsa; permitted write SHALL clear bit wa.
REQ-012 Simultaneous set and write to the same address SHALL leave the bit set (set wins).
REQ-013 busy0/busy1 SHALL reflect stored bits combinationally, no bypass of the same-cycle set/clear.
REQ-014 Clear FSM states IDLE, SWEEP; IDLE->SWEEP on clr_req=1 at edge; counter loads 0.
REQ-015 In SWEEP, each edge SHALL zero register idx and clear busy idx, then increment idx; after idx=DEPTH-1 is cleared, FSM SHALL return to IDLE. Sweep takes exactly DEPTH cycles.
REQ-016 clr_busy SHALL be 1 exactly while state=SWEEP (registered output).
REQ-017 During SWEEP, we, bs and further clr_req SHALL be ignored; reads return stored values without bypass.
REQ-018 clr_req held high at sweep end SHALL start a new sweep on the next edge in IDLE.

Reset
REQ-019 reset=1 SHALL immediately force all registers to 0, all busy bits 0, FSM IDLE, idx 0, clr_busy 0, regardless of clock.
REQ-020 Reset asserted mid-sweep SHALL abort it; after release the block SHALL be IDLE and accept writes on the first edge.

Structure
REQ-021 Shared package rf_pkg SHALL hold the FSM state encoding (IDLE=0, SWEEP=1) and the clog2 function.
REQ-022 The sweep FSM and index counter SHALL be one sub-module, rf_clear_seq, outputting clr_busy, clr_idx and a per-cycle clear strobe.
REQ-023 Storage, bypass and scoreboard SHALL reside in param_register_file.

Verification
REQ-024 Default params: write 0xDEADBEEF to r5, next cycle ra0=5 -> out0=0xDEADBEEF; same cycle ra1=5, we=1 -> out1=wd (bypass).
REQ-025 Write 0x12345678 to r0 with ZERO_REG=1 -> out0=0 for ra0=0; with ZERO_REG=0 -> 0x12345678.
REQ-026 bs=1, bsa=7 -> busy0=1 next cycle for ra0=7; write r7 -> busy0=0; same-edge bs and write to r7 -> busy0 stays 1.
REQ-027 Fill r1..r31 nonzero, pulse clr_req -> clr_busy high exactly 32 cycles, we ignored throughout, then all reads 0.
REQ-028 Assert reset at sweep cycle 10 without clock edge -> outputs 0, clr_busy 0 immediately; write after release succeeds.
REQ-029 DEPTH=20, WIDTH=16: write to address 25 ignored, ra0=25 -> out0=0; sweep lasts 20 cycles.
